// File: rtl/bp_stall_hist_reader.sv
// Per-hart stall-attribution counter bank: one event per counted cycle bumps a
// counter, and a single-outstanding request channel reads counters back with optional clear.
module bp_stall_hist_reader #(
  parameter int num_reasons_p   = 21,
  parameter int counter_width_p = 32,
  parameter int addr_width_p    = 5,
  localparam int num_cnt_lp     = num_reasons_p + 3,
  // The read port must be wide enough to return the full saturation mask.
  localparam int data_width_lp  = (counter_width_p > num_cnt_lp) ? counter_width_p : num_cnt_lp
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     en_i,
  input  logic                     freeze_i,
  input  logic                     commit_v_i,
  input  logic                     stall_reason_v_i,
  input  logic [4:0]               stall_reason_i,
  input  logic                     req_v_i,
  output logic                     req_ready_o,
  input  logic [addr_width_p-1:0]  req_addr_i,
  input  logic                     req_clear_i,
  input  logic                     req_clear_all_i,
  output logic                     resp_v_o,
  input  logic                     resp_yumi_i,
  output logic [data_width_lp-1:0] resp_data_o,
  output logic                     resp_err_o,
  output logic [0:0]               dbg_state_o
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;
  localparam logic [addr_width_p-1:0] INSTR_ADDR = addr_width_p'(num_reasons_p);
  localparam logic [addr_width_p-1:0] UNK_ADDR   = addr_width_p'(num_reasons_p + 1);
  localparam logic [addr_width_p-1:0] MASK_ADDR  = addr_width_p'(num_reasons_p + 3);
  localparam logic [counter_width_p-1:0] CNT_MAX = '1;
  localparam logic [counter_width_p-1:0] CNT_ONE = counter_width_p'(1);

  logic [counter_width_p-1:0] r_cnt     [num_cnt_lp];
  logic [counter_width_p-1:0] w_cnt_nxt [num_cnt_lp];
  logic [num_cnt_lp-1:0]      r_mask;
  logic [num_cnt_lp-1:0]      w_mask_nxt;
  logic [num_cnt_lp-1:0]      w_inc;
  logic [num_cnt_lp-1:0]      w_clr;
  logic [0:0]                 r_state;
  logic [data_width_lp-1:0]   r_resp_data;
  logic [data_width_lp-1:0]   w_rd_data;
  logic                       r_resp_err;
  logic                       w_rd_err;
  logic                       w_accept;
  logic                       w_count;
  logic [addr_width_p-1:0]    w_evt_idx;

  // Handshake: a request transfers on a cycle with req_v_i & req_ready_o; the
  // response is held until a cycle with resp_v_o & resp_yumi_i consumes it.
  assign req_ready_o = (r_state == ST_IDLE);
  assign resp_v_o    = (r_state == ST_RESP);
  assign resp_data_o = r_resp_data;
  assign resp_err_o  = r_resp_err;
  assign dbg_state_o = r_state;
  assign w_accept    = req_v_i & req_ready_o;
  assign w_count     = en_i & ~freeze_i;

  always_comb begin
    if (commit_v_i)
      w_evt_idx = INSTR_ADDR;
    else if (stall_reason_v_i && (int'(stall_reason_i) < num_reasons_p))
      w_evt_idx = addr_width_p'(stall_reason_i);
    else
      w_evt_idx = UNK_ADDR;
  end

  // Clear wins over the stale value but never swallows this cycle's event.
  always_comb begin
    w_inc      = '0;
    w_clr      = '0;
    w_mask_nxt = r_mask;
    for (int i = 0; i < num_cnt_lp; i++) begin
      w_inc[i] = w_count & ((i == num_cnt_lp - 1) || (w_evt_idx == addr_width_p'(i)));
      w_clr[i] = w_accept & (req_clear_all_i | (req_clear_i & (req_addr_i == addr_width_p'(i))));
      if (w_clr[i])
        w_cnt_nxt[i] = w_inc[i] ? CNT_ONE : '0;
      else if (w_inc[i] && (r_cnt[i] != CNT_MAX))
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      else
        w_cnt_nxt[i] = r_cnt[i];
    end
    if (w_accept && (req_clear_all_i || (req_clear_i && (req_addr_i == MASK_ADDR))))
      w_mask_nxt = '0;
    for (int j = 0; j < num_cnt_lp; j++) begin
      if (w_inc[j] && (w_cnt_nxt[j] == CNT_MAX))
        w_mask_nxt[j] = 1'b1;
    end
  end

  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (req_addr_i == MASK_ADDR) begin
      w_rd_data = data_width_lp'(r_mask);
    end else if (req_addr_i > MASK_ADDR) begin
      w_rd_err = 1'b1;
    end else begin
      for (int i = 0; i < num_cnt_lp; i++) begin
        if (req_addr_i == addr_width_p'(i))
          w_rd_data = data_width_lp'(r_cnt[i]);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state     <= ST_IDLE;
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
      r_mask      <= '0;
      for (int i = 0; i < num_cnt_lp; i++) r_cnt[i] <= '0;
    end else begin
      r_mask <= w_mask_nxt;
      for (int i = 0; i < num_cnt_lp; i++) r_cnt[i] <= w_cnt_nxt[i];
      if (r_state == ST_IDLE) begin
        if (w_accept) begin
          r_state     <= ST_RESP;
          r_resp_data <= w_rd_data;
          r_resp_err  <= w_rd_err;
        end
      end else if (resp_yumi_i) begin
        r_state <= ST_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_bp_stall_hist_reader.sv
// Directed bench for bp_stall_hist_reader: a 32-bit instance for normal behaviour
// and a 4-bit instance sharing the same inputs for saturation behaviour.
module tb_bp_stall_hist_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, en, freeze, commit_v, stall_v;
  logic [4:0] stall_reason;
  logic       req_v, req_clear, req_clear_all, resp_yumi;
  logic [4:0] req_addr;

  logic        req_ready, resp_v, resp_err;
  logic [31:0] resp_data;
  logic [0:0]  dbg_state;
  logic        req_ready_n, resp_v_n, resp_err_n;
  logic [23:0] resp_data_n;
  logic [0:0]  dbg_state_n;

  bp_stall_hist_reader dut (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .freeze_i(freeze),
    .commit_v_i(commit_v), .stall_reason_v_i(stall_v), .stall_reason_i(stall_reason),
    .req_v_i(req_v), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_clear_i(req_clear), .req_clear_all_i(req_clear_all),
    .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data),
    .resp_err_o(resp_err), .dbg_state_o(dbg_state)
  );

  bp_stall_hist_reader #(.counter_width_p(4)) dut_n (
    .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .freeze_i(freeze),
    .commit_v_i(commit_v), .stall_reason_v_i(stall_v), .stall_reason_i(stall_reason),
    .req_v_i(req_v), .req_ready_o(req_ready_n), .req_addr_i(req_addr),
    .req_clear_i(req_clear), .req_clear_all_i(req_clear_all),
    .resp_v_o(resp_v_n), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data_n),
    .resp_err_o(resp_err_n), .dbg_state_o(dbg_state_n)
  );

  typedef struct {
    logic [4:0]  addr;
    logic        clr;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rd_data;
  logic        rd_err;
  logic [23:0] rd_data_n;
  logic [31:0] exp_q[$];
  int          exp_cnt[24];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_ev(input logic e, input logic f, input logic c, input logic v,
                        input logic [4:0] r);
    en = e; freeze = f; commit_v = c; stall_v = v; stall_reason = r;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    set_ev(1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    req_v = 1'b0; req_clear = 1'b0; req_clear_all = 1'b0; resp_yumi = 1'b0; req_addr = 5'd0;
    tick(3);
    reset_n = 1'b1;
  endtask

  task automatic do_read(input logic [4:0] addr, input logic clr, input logic clr_all);
    int waited;
    waited = 0;
    @(negedge clk);
    req_v = 1'b1; req_addr = addr; req_clear = clr; req_clear_all = clr_all;
    while (!req_ready && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
    tick(1);
    check($sformatf("resp_v_after_accept a%0d", addr), 64'(resp_v), 64'd1);
    @(negedge clk);
    req_v = 1'b0; req_clear = 1'b0; req_clear_all = 1'b0;
    rd_data = resp_data; rd_err = resp_err; rd_data_n = resp_data_n;
    resp_yumi = 1'b1;
    tick(1);
    resp_yumi = 1'b0;
  endtask

  vec_t tbl[15];
  logic [31:0] exp_after[25];
  longint sum;

  initial begin
    tbl[0]  = '{5'd0,  1'b0, 32'd2,  1'b0};
    tbl[1]  = '{5'd16, 1'b0, 32'd5,  1'b0};
    tbl[2]  = '{5'd20, 1'b0, 32'd1,  1'b0};
    tbl[3]  = '{5'd21, 1'b0, 32'd10, 1'b0};
    tbl[4]  = '{5'd22, 1'b0, 32'd8,  1'b0};
    tbl[5]  = '{5'd23, 1'b0, 32'd26, 1'b0};
    tbl[6]  = '{5'd24, 1'b0, 32'd0,  1'b0};
    tbl[7]  = '{5'd5,  1'b0, 32'd0,  1'b0};
    tbl[8]  = '{5'd25, 1'b0, 32'd0,  1'b1};
    tbl[9]  = '{5'd27, 1'b1, 32'd0,  1'b1};
    tbl[10] = '{5'd31, 1'b0, 32'd0,  1'b1};
    tbl[11] = '{5'd16, 1'b1, 32'd5,  1'b0};
    tbl[12] = '{5'd16, 1'b0, 32'd0,  1'b0};
    tbl[13] = '{5'd23, 1'b0, 32'd26, 1'b0};
    tbl[14] = '{5'd21, 1'b0, 32'd10, 1'b0};

    // Reset state
    do_reset();
    check("reset_ready", 64'(req_ready), 64'd1);
    check("reset_resp_v", 64'(resp_v), 64'd0);
    check("reset_data", 64'(resp_data), 64'd0);
    check("reset_err", 64'(resp_err), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);

    // Event mix with freeze, disabled cycles and out-of-range reasons
    set_ev(1, 0, 1, 0, 5'd0);  tick(10);
    set_ev(1, 0, 0, 1, 5'd16); tick(5);
    set_ev(1, 1, 0, 1, 5'd16); tick(7);
    set_ev(1, 0, 0, 1, 5'd25); tick(3);
    set_ev(0, 0, 1, 0, 5'd0);  tick(2);
    set_ev(1, 0, 0, 0, 5'd0);  tick(4);
    set_ev(1, 0, 0, 1, 5'd0);  tick(2);
    set_ev(1, 0, 0, 1, 5'd20); tick(1);
    set_ev(1, 0, 0, 1, 5'd21); tick(1);
    set_ev(0, 0, 0, 0, 5'd0);

    for (int k = 0; k < 15; k++) begin
      do_read(tbl[k].addr, tbl[k].clr, 1'b0);
      check($sformatf("tbl%0d_data a%0d", k, tbl[k].addr), 64'(rd_data), 64'(tbl[k].exp_data));
      check($sformatf("tbl%0d_err a%0d", k, tbl[k].addr), 64'(rd_err), 64'(tbl[k].exp_err));
    end

    // Response held while yumi stays low
    @(negedge clk);
    req_v = 1'b1; req_addr = 5'd21;
    tick(1);
    req_v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("hold%0d_resp_v", k), 64'(resp_v), 64'd1);
      check($sformatf("hold%0d_data", k), 64'(resp_data), 64'd10);
      check($sformatf("hold%0d_ready", k), 64'(req_ready), 64'd0);
      check($sformatf("hold%0d_state", k), 64'(dbg_state), 64'd1);
      tick(1);
    end
    @(negedge clk);
    resp_yumi = 1'b1;
    tick(1);
    resp_yumi = 1'b0;
    check("hold_release_ready", 64'(req_ready), 64'd1);
    check("hold_release_resp_v", 64'(resp_v), 64'd0);

    // Reset while a response is pending
    @(negedge clk);
    req_v = 1'b1; req_addr = 5'd21;
    tick(1);
    req_v = 1'b0;
    check("pre_reset_resp_v", 64'(resp_v), 64'd1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    check("rst_resp_resp_v", 64'(resp_v), 64'd0);
    check("rst_resp_ready", 64'(req_ready), 64'd1);
    check("rst_resp_data", 64'(resp_data), 64'd0);
    do_read(5'd21, 1'b0, 1'b0);
    check("rst_resp_instr_zero", 64'(rd_data), 64'd0);

    // Saturation on the 4-bit instance
    do_reset();
    set_ev(1, 0, 0, 0, 5'd0); tick(20);
    set_ev(0, 0, 0, 0, 5'd0);
    do_read(5'd22, 1'b0, 1'b0);
    check("sat_unknown_n", 64'(rd_data_n), 64'd15);
    check("sat_unknown_wide", 64'(rd_data), 64'd20);
    do_read(5'd23, 1'b0, 1'b0);
    check("sat_total_n", 64'(rd_data_n), 64'd15);
    do_read(5'd24, 1'b1, 1'b0);
    check("sat_mask_n", 64'(rd_data_n), 64'hC0_0000);
    check("sat_mask_wide", 64'(rd_data), 64'd0);
    do_read(5'd24, 1'b0, 1'b0);
    check("sat_mask_cleared_n", 64'(rd_data_n), 64'd0);
    do_read(5'd22, 1'b0, 1'b0);
    check("sat_mask_clear_keeps_cnt_n", 64'(rd_data_n), 64'd15);

    // Clear racing an increment on the same counter
    do_reset();
    set_ev(1, 0, 1, 0, 5'd0); tick(3);
    do_read(5'd21, 1'b1, 1'b0);
    set_ev(0, 0, 0, 0, 5'd0);
    check("clr_race_snapshot", 64'(rd_data), 64'd3);
    do_read(5'd21, 1'b0, 1'b0);
    check("clr_race_instr_after", 64'(rd_data), 64'd2);
    do_read(5'd23, 1'b0, 1'b0);
    check("clr_race_total", 64'(rd_data), 64'd5);

    // Random event mix against a reference count
    do_reset();
    for (int i = 0; i < 24; i++) exp_cnt[i] = 0;
    for (int c = 0; c < 1000; c++) begin
      set_ev($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)));
      if (en && !freeze) begin
        exp_cnt[23]++;
        if (commit_v) exp_cnt[21]++;
        else if (stall_v && stall_reason < 5'd21) exp_cnt[stall_reason]++;
        else exp_cnt[22]++;
      end
      tick(1);
    end
    set_ev(0, 0, 0, 0, 5'd0);
    sum = 0;
    for (int a = 0; a < 24; a++) begin
      exp_q.push_back(32'(exp_cnt[a]));
      do_read(5'(a), 1'b0, 1'b0);
      check($sformatf("rand_a%0d", a), 64'(rd_data), 64'(exp_q.pop_front()));
      if (a < 23) sum += longint'(rd_data);
    end
    check("rand_sum_vs_total", 64'(sum), 64'(rd_data));
    do_read(5'd24, 1'b0, 1'b0);
    check("rand_mask", 64'(rd_data), 64'd0);

    // Clear-all (with a competing single clear) while commits keep counting
    set_ev(1, 0, 1, 0, 5'd0);
    do_read(5'd5, 1'b1, 1'b1);
    set_ev(0, 0, 0, 0, 5'd0);
    check("clrall_snapshot", 64'(rd_data), 64'(exp_cnt[5]));
    for (int a = 0; a < 25; a++) exp_after[a] = 32'd0;
    exp_after[21] = 32'd2;
    exp_after[23] = 32'd2;
    for (int a = 0; a < 25; a++) begin
      exp_q.push_back(exp_after[a]);
      do_read(5'(a), 1'b0, 1'b0);
      check($sformatf("clrall_race_a%0d", a), 64'(rd_data), 64'(exp_q.pop_front()));
    end
    do_read(5'd21, 1'b1, 1'b1);
    for (int a = 0; a < 25; a++) begin
      exp_q.push_back(32'd0);
      do_read(5'(a), 1'b0, 1'b0);
      check($sformatf("clrall_zero_a%0d", a), 64'(rd_data), 64'(exp_q.pop_front()));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
